dcache_wt: RTL
==============

# dcache_wt

Direct-mapped, write-through, no-write-allocate data cache between the pipelined datapath's data-memory port (DM_*) and a slow, handshaked main memory. Read hits return data in the same cycle as the MEM-stage request. Misses and all stores hold `DM_stall` high until the memory transaction completes. The datapath freezes every pipeline register and the PC while `DM_stall`=1.

## Interface
- `N`, 64: data/address width; the word size is fixed at 64 bits (8 bytes).
- `LINES`, 8: number of one-word lines; must be a power of 2 and ≥2. `IW` = log2(`LINES`).
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `DM_addr`  in  N  byte address from the MEM stage. Bits [2:0] are ignored. Index = [IW+2:3], tag = [N-1:IW+3].
- `DM_writeData`  in  N  store data.
- `DM_readEnable`  in  1  load request.
- `DM_writeEnable`  in  1  store request. Has priority if asserted together with `DM_readEnable`.
- `DM_readData`  out  N  load data; the line data on a read hit, otherwise 0.
- `DM_stall`  out  1  freeze request to the datapath.
- `mem_req`  out  1  main-memory request, held until acknowledged.
- `mem_we`  out  1  1 = write transaction, 0 = read.
- `mem_addr`  out  N  word-aligned address (bits [2:0] = 0).
- `mem_wdata`  out  N  write data.
- `mem_ack`  in  1  one-cycle completion pulse from memory.
- `mem_rdata`  in  N  read data, valid in the cycle `mem_ack`=1.

## Operation
Storage per line: valid bit, tag of N-IW-3 bits, and a 64-bit data word.

hit = valid[index] && tag[index]==tag(DM_addr).

FSM states are IDLE, FILL, WRITE and WDONE.

- **IDLE**
  - Read, no write, hit: `DM_stall`=0 and `DM_readData`=line data. State stays IDLE.
  - Read miss: `DM_stall`=1 combinationally. At the next edge, capture the aligned `mem_addr` and set `mem_we`=0. Go to FILL.
  - Write (hit or miss): `DM_stall`=1. At the next edge, capture `mem_addr` and `mem_wdata` and set `mem_we`=1. Go to WRITE.
  - No request: `DM_stall`=0 and the state is unchanged.
- **FILL**
  - `mem_req`=1 and `DM_stall`=1.
  - On `mem_ack`, at that edge: line[index] ← {valid=1, tag, `mem_rdata`}. Go to IDLE.
  - The held request then hits in IDLE and `DM_stall` drops.
- **WRITE**
  - `mem_req`=1 and `DM_stall`=1.
  - On `mem_ack`: if the line hit at capture time, line data ← `mem_wdata` (write-through update). On a miss, the array is untouched (no allocate). Go to WDONE.
- **WDONE**
  - `DM_stall`=0 and `mem_req`=0 for exactly one cycle, which lets the pipeline retire the held store.
  - Unconditionally go to IDLE. A new request presented in WDONE is not serviced until IDLE.
- `mem_req` = (state==FILL || state==WRITE), decoded from registered state only.
- `mem_addr`, `mem_wdata` and `mem_we` are stable from request entry until the cycle after the ack.
- `mem_ack` is ignored in IDLE and WDONE.
- The tag/index used in FILL/WRITE come from the captured `mem_addr`, not from the live `DM_addr`.

## Timing
- Reset (`reset`=0), asynchronous:
  - State goes to IDLE and all valid bits clear.
  - `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
  - Tag and data arrays are not reset.
  - With all lines invalid, `DM_readData`=0.
  - `DM_stall` follows the IDLE rules, so it is 1 if a request is presented.
- Reset mid-transaction: the transaction is abandoned, `mem_req` drops immediately, and no line is written.
- Read hit latency: 0 cycles (combinational).
- Read miss: `DM_stall` high for 1 + A cycles, where A = cycles from `mem_req` rise to `mem_ack`, inclusive.
- Store: `DM_stall` high for 1 + A cycles, followed by one WDONE cycle with `DM_stall`=0.
- `mem_ack` may arrive in the first cycle of FILL/WRITE (A=1).
- Both enables high at once: treated as a write only.
- Index aliasing: a fill to an index overwrites its previous contents.

## Test plan
1. **Reset then cold read.** Stimulus: release reset; read `DM_addr`=0x40; `mem_ack` after 3 cycles with `mem_rdata`=0xDEAD. Required: `DM_stall`=1 for 4 cycles; `mem_addr`=0x40, `mem_we`=0; then `DM_readData`=0xDEAD with `DM_stall`=0.
2. **Read hit.** Stimulus: repeat the read of 0x40, then read 0x44 (same word). Required: both return 0xDEAD with `DM_stall`=0 and `mem_req`=0.
3. **Store hit, write-through.** Stimulus: write 0xBEEF to 0x40; ack after 2 cycles. Required: `mem_we`=1, `mem_wdata`=0xBEEF; `DM_stall`=1 for 3 cycles, then one WDONE cycle with `DM_stall`=0; a later read of 0x40 hits and returns 0xBEEF.
4. **Store miss, no allocate.** Stimulus: write 0x1 to 0x240, which has the same index as 0x40 (LINES=8). Required: a memory write is issued; a read of 0x40 still hits with 0xBEEF; a read of 0x240 misses.
5. **Conflict eviction.** Stimulus: read 0x240 with `mem_rdata`=0x77. Required: line refilled; a subsequent read of 0x40 misses and issues `mem_req`.
6. **Reset during FILL and same-cycle ack.** Stimulus: assert `reset` low in the second FILL cycle. Required: `mem_req`=0 immediately and a re-read of that address misses. Separately, `mem_ack` in the first FILL cycle gives `DM_stall` high for exactly 2 cycles.

Source files
------------

// File: rtl/dcache_wt.sv
// Direct-mapped, write-through, no-write-allocate data cache with one-word lines.
// Read hits return data combinationally; misses and stores stall the datapath until main memory acks.
module dcache_wt #(
  parameter int unsigned N     = 64,
  parameter int unsigned LINES = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] DM_addr,
  input  logic [N-1:0] DM_writeData,
  input  logic         DM_readEnable,
  input  logic         DM_writeEnable,
  output logic [N-1:0] DM_readData,
  output logic         DM_stall,
  output logic         mem_req,
  output logic         mem_we,
  output logic [N-1:0] mem_addr,
  output logic [N-1:0] mem_wdata,
  input  logic         mem_ack,
  input  logic [N-1:0] mem_rdata
);

  localparam int unsigned IW = $clog2(LINES);
  localparam int unsigned TW = N - IW - 3;

  typedef enum logic [1:0] {IDLE, FILL, WRITE, WDONE} state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   mem_addr_q, mem_addr_d;
  logic [N-1:0]   mem_wdata_q, mem_wdata_d;
  logic           mem_we_q, mem_we_d;
  logic           hit_cap_q, hit_cap_d;
  logic [LINES-1:0] valid_q, valid_d;

  logic [TW-1:0]  tag_q  [LINES];
  logic [N-1:0]   data_q [LINES];

  logic [IW-1:0]  req_idx_c, cap_idx_c;
  logic [TW-1:0]  req_tag_c, cap_tag_c;
  logic           hit_c;
  logic           fill_c, upd_c;

  // Live lookup uses the MEM-stage address; array updates use the captured one.
  assign req_idx_c = DM_addr[IW+2:3];
  assign req_tag_c = DM_addr[N-1:IW+3];
  assign cap_idx_c = mem_addr_q[IW+2:3];
  assign cap_tag_c = mem_addr_q[N-1:IW+3];
  assign hit_c     = valid_q[req_idx_c] && (tag_q[req_idx_c] == req_tag_c);

  assign DM_readData = (DM_readEnable && !DM_writeEnable && hit_c) ? data_q[req_idx_c] : '0;
  assign mem_req     = (state_q == FILL) || (state_q == WRITE);
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;

  // Next-state, request capture and array-update decode.
  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_we_d    = mem_we_q;
    hit_cap_d   = hit_cap_q;
    valid_d     = valid_q;
    fill_c      = 1'b0;
    upd_c       = 1'b0;
    DM_stall    = 1'b0;
    case (state_q)
      IDLE: begin
        if (DM_writeEnable) begin
          DM_stall    = 1'b1;
          state_d     = WRITE;
          mem_addr_d  = DM_addr & ~N'(7);
          mem_wdata_d = DM_writeData;
          mem_we_d    = 1'b1;
          hit_cap_d   = hit_c;
        end else if (DM_readEnable && !hit_c) begin
          DM_stall    = 1'b1;
          state_d     = FILL;
          mem_addr_d  = DM_addr & ~N'(7);
          mem_we_d    = 1'b0;
        end
      end
      FILL: begin
        DM_stall = 1'b1;
        if (mem_ack) begin
          valid_d[cap_idx_c] = 1'b1;
          fill_c  = 1'b1;
          state_d = IDLE;
        end
      end
      WRITE: begin
        DM_stall = 1'b1;
        if (mem_ack) begin
          upd_c   = hit_cap_q;
          state_d = WDONE;
        end
      end
      WDONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      hit_cap_q   <= 1'b0;
      valid_q     <= '0;
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_we_q    <= mem_we_d;
      hit_cap_q   <= hit_cap_d;
      valid_q     <= valid_d;
    end
  end

  // Tag and data arrays carry no reset; validity alone gates hits.
  always_ff @(posedge clk) begin
    if (fill_c) begin
      tag_q[cap_idx_c]  <= cap_tag_c;
      data_q[cap_idx_c] <= mem_rdata;
    end else if (upd_c) begin
      data_q[cap_idx_c] <= mem_wdata_q;
    end
  end

endmodule
